// File: rtl/alu_cc_writeback_stage_if.sv
// Handshake, result, condition-code and branch signals between the ALU, this stage and writeback.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's view.
interface alu_cc_writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_z;
    logic              in_n;
    logic              in_c;
    logic              in_v;
    logic [5:0]        in_op;
    logic [RD_W-1:0]   in_rd;
    logic              in_we;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_we;
    logic [3:0]        icc;
    logic              cin_out;
    logic [3:0]        cond;
    logic              cond_eval;
    logic              branch_valid;
    logic              branch_taken;

    modport slave (
        input  in_valid, in_result, in_z, in_n, in_c, in_v, in_op, in_rd, in_we,
        output in_ready,
        output out_valid, out_result, out_rd, out_we,
        input  out_ready,
        output icc, cin_out,
        input  cond, cond_eval,
        output branch_valid, branch_taken
    );

    modport master (
        output in_valid, in_result, in_z, in_n, in_c, in_v, in_op, in_rd, in_we,
        input  in_ready,
        input  out_valid, out_result, out_rd, out_we,
        output out_ready,
        input  icc, cin_out,
        output cond, cond_eval,
        input  branch_valid, branch_taken
    );
endinterface

// File: rtl/alu_cc_writeback_stage.sv
// ALU writeback stage: 2-entry skid buffer, icc register with ALU carry feedback, Bicc evaluation.
// Define ICC_BYPASS_EN to let branch evaluation and cin_out see the icc value written this cycle.
module alu_cc_writeback_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input logic                    clk,
    input logic                    reset,
    alu_cc_writeback_stage_if.slave bus
);
    localparam int ENT_W = DATA_W + RD_W + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t       state, state_next;
    logic             push, pop;
    logic             head_load, head_shift, tail_load;
    logic [ENT_W-1:0] in_entry, head_q, tail_q;
    logic [3:0]       icc_q, icc_next, icc_eval;
    logic             icc_wr;
    logic             taken_raw;
    logic             branch_valid_q, branch_taken_q;
    logic             unused_op;

    assign unused_op = ^bus.in_op[3:2];

    // Handshake flags come from the state register only, so there is no in-to-out combinational path.
    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;
    assign in_entry = {bus.in_we, bus.in_rd, bus.in_result};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        head_load  = 1'b0;
        head_shift = 1'b0;
        tail_load  = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    head_load  = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_load = 1'b1;
                end else if (push) begin
                    state_next = FULL;
                    tail_load  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next = ONE;
                    head_shift = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Head is never cleared on pop so the outputs hold their last value while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (head_load)       head_q <= in_entry;
            else if (head_shift) head_q <= tail_q;
            if (tail_load)       tail_q <= in_entry;
        end
    end

    assign {bus.out_we, bus.out_rd, bus.out_result} = head_q;

    assign icc_wr = push && (bus.in_op[5:4] == 2'b01);

    always_comb begin
        icc_next = icc_q;
        if (icc_wr) begin
            if (bus.in_op[1:0] == 2'b00) icc_next = {bus.in_n, bus.in_z, bus.in_v, bus.in_c};
            else                         icc_next = {bus.in_n, bus.in_z, 2'b00};
        end
    end

`ifdef ICC_BYPASS_EN
    assign icc_eval = icc_next;
`else
    assign icc_eval = icc_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) icc_q <= 4'b0000;
        else       icc_q <= icc_next;
    end

    assign bus.icc     = icc_q;
    assign bus.cin_out = icc_eval[0];

    // icc layout is {N,Z,V,C}; cond[3] inverts the base condition selected by cond[2:0].
    always_comb begin
        taken_raw = 1'b0;
        case (bus.cond[2:0])
            3'b000: taken_raw = 1'b0;
            3'b001: taken_raw = icc_eval[2];
            3'b010: taken_raw = icc_eval[2] | (icc_eval[3] ^ icc_eval[1]);
            3'b011: taken_raw = icc_eval[3] ^ icc_eval[1];
            3'b100: taken_raw = icc_eval[0] | icc_eval[2];
            3'b101: taken_raw = icc_eval[0];
            3'b110: taken_raw = icc_eval[3];
            3'b111: taken_raw = icc_eval[1];
            default: taken_raw = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_valid_q <= 1'b0;
            branch_taken_q <= 1'b0;
        end else begin
            branch_valid_q <= bus.cond_eval;
            if (bus.cond_eval) branch_taken_q <= taken_raw ^ bus.cond[3];
        end
    end

    assign bus.branch_valid = branch_valid_q;
    assign bus.branch_taken = branch_taken_q;
endmodule
